// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: buffered TX toward the arbiter and an
// address-filtered, buffered RX path toward the device.
//
// Ports:
//   clk, reset       rising-edge clock, async active-low reset
//   tx_push/tx_data  device -> TX FIFO write
//   tx_full          TX FIFO holds depth entries
//   pndng/D_pop      TX FIFO not empty / fall-through head (to arbiter)
//   pop              arbiter consumes TX head
//   push/D_push      arbiter delivers a packet to this port
//   rx_valid/rx_data RX FIFO not empty / fall-through head (to device)
//   rx_pop           device consumes RX head
//   tx_drops         saturating count of TX writes refused for lack of space
//   rx_drops         saturating count of address-matched packets lost to RX full

module bus_dev_port_fifo #(
    parameter int width = 32,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [width-1:0] wr_data,
    input  logic             rd_req,
    output logic             full,
    output logic             not_empty,
    output logic [width-1:0] head,
    output logic [7:0]       drops
);
    localparam int aw = $clog2(depth);

    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic [width-1:0] mem [depth];
    logic             empty;
    logic             rd_en;
    logic             wr_en;
    logic             drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) &&
                   (wptr[aw] != rptr[aw]);

    assign rd_en = rd_req && !empty;
    // A read in the same cycle frees the slot the write lands in,
    // so a full FIFO still takes the write.
    assign wr_en = wr_req && (!full || rd_en);
    assign drop  = wr_req && !wr_en;

    assign not_empty = !empty;
    assign head      = empty ? '0 : mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[aw-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            drops <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + {{aw{1'b0}}, 1'b1};
            end
            if (rd_en) begin
                rptr <= rptr + {{aw{1'b0}}, 1'b1};
            end
            if (drop && drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end
endmodule

module bus_dev_port #(
    parameter int         pckg_sz   = 32,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_pop,
    output logic [7:0]         tx_drops,
    output logic [7:0]         rx_drops
);
    logic [7:0] dest;
    logic       rx_match;
    logic       rx_full;

    assign dest     = D_push[pckg_sz-1 -: 8];
    assign rx_match = push && (dest == id || dest == broadcast);

    bus_dev_port_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (tx_push),
        .wr_data   (tx_data),
        .rd_req    (pop),
        .full      (tx_full),
        .not_empty (pndng),
        .head      (D_pop),
        .drops     (tx_drops)
    );

    // Only address-matched packets reach the RX FIFO, so filtered
    // traffic never counts as a drop.
    bus_dev_port_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (rx_match),
        .wr_data   (D_push),
        .rd_req    (rx_pop),
        .full      (rx_full),
        .not_empty (rx_valid),
        .head      (rx_data),
        .drops     (rx_drops)
    );

    logic unused_ok;
    assign unused_ok = rx_full;
endmodule
